// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller handshake bundle for sdram_port_arbiter.
// The arbiter takes the master modport; the requesters and controller take the slave side.
interface sdram_port_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 24
);
  logic [NPORTS-1:0]        REQ;
  logic [NPORTS-1:0]        RW;
  logic [NPORTS*ADDR_W-1:0] ADR;
  logic [NPORTS-1:0]        GNT;
  logic [NPORTS-1:0]        ACK;
  logic                     CMD_VALID;
  logic                     CMD_REF;
  logic                     CMD_RW;
  logic [ADDR_W-1:0]        CMD_ADR;
  logic                     CMD_READY;
  logic                     CMD_DONE;

  modport master (
    input  REQ, RW, ADR, CMD_READY, CMD_DONE,
    output GNT, ACK, CMD_VALID, CMD_REF, CMD_RW, CMD_ADR
  );

  modport slave (
    output REQ, RW, ADR, CMD_READY, CMD_DONE,
    input  GNT, ACK, CMD_VALID, CMD_REF, CMD_RW, CMD_ADR
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller between NPORTS requesters and schedules auto-refresh.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins port priority instead of round-robin.
module sdram_port_arbiter #(
  parameter int NPORTS        = 3,
  parameter int ADDR_W        = 24,
  parameter int REFR_INTERVAL = 780,
  parameter int MAX_PENDING   = 8,
  parameter int URGENT_LEVEL  = 4
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 INIT_DONE,
  sdram_port_arbiter_if.master bus,
  output logic                 BUSY,
  output logic                 REF_OVERDUE
);

  localparam int PTR_W  = $clog2(NPORTS);
  localparam int TMR_W  = $clog2(REFR_INTERVAL);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [NPORTS-1:0]   gnt_q, gnt_d;
  logic                cmd_ref_q, cmd_ref_d;
  logic                cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0]   cmd_adr_q, cmd_adr_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]    ptr_q, ptr_d;
`endif

  logic                tick;
  logic                ref_done;
  logic                start;
  logic                refresh_sel;
  logic [PTR_W-1:0]    sel_idx;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      gnt_q     <= '0;
      cmd_ref_q <= 1'b0;
      cmd_rw_q  <= 1'b0;
      cmd_adr_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      cmd_ref_q <= cmd_ref_d;
      cmd_rw_q  <= cmd_rw_d;
      cmd_adr_q <= cmd_adr_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // Later loop iterations override earlier ones, so the lowest qualifying index wins;
  // in round-robin mode ports at or above the pointer override those below it.
  always_comb begin
    sel_idx = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int j = NPORTS - 1; j >= 0; j--)
      if (bus.REQ[j]) sel_idx = PTR_W'(j);
`else
    for (int j = NPORTS - 1; j >= 0; j--)
      if (bus.REQ[j] && (j < int'(ptr_q))) sel_idx = PTR_W'(j);
    for (int j = NPORTS - 1; j >= 0; j--)
      if (bus.REQ[j] && (j >= int'(ptr_q))) sel_idx = PTR_W'(j);
`endif
  end

  assign start       = INIT_DONE && ((pending_q != '0) || (|bus.REQ));
  assign refresh_sel = (pending_q >= PEND_W'(URGENT_LEVEL)) ||
                       ((pending_q != '0) && (bus.REQ == '0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)         state_d = ISSUE;
      ISSUE:     if (bus.CMD_READY) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.CMD_DONE)  state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    tick      = INIT_DONE && (timer_q == TMR_W'(REFR_INTERVAL - 1));
    ref_done  = (state_q == WAIT_DONE) && bus.CMD_DONE && cmd_ref_q;
    timer_d   = (!INIT_DONE || tick) ? '0 : timer_q + 1'b1;
    pending_d = pending_q;
    if (tick && !ref_done && (pending_q != PEND_W'(MAX_PENDING)))
      pending_d = pending_q + 1'b1;
    else if (ref_done && !tick)
      pending_d = pending_q - 1'b1;

    gnt_d     = gnt_q;
    cmd_ref_d = cmd_ref_q;
    cmd_rw_d  = cmd_rw_q;
    cmd_adr_d = cmd_adr_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    if ((state_q == IDLE) && start) begin
      if (refresh_sel) begin
        cmd_ref_d = 1'b1;
        gnt_d     = '0;
      end else begin
        cmd_ref_d = 1'b0;
        gnt_d     = NPORTS'(1) << sel_idx;
        cmd_rw_d  = bus.RW[sel_idx];
        cmd_adr_d = bus.ADR[sel_idx*ADDR_W +: ADDR_W];
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        ptr_d     = (sel_idx == PTR_W'(NPORTS - 1)) ? '0 : sel_idx + 1'b1;
`endif
      end
    end else if ((state_q == WAIT_DONE) && bus.CMD_DONE) begin
      gnt_d = '0;
    end
  end

  always_comb begin
    bus.CMD_VALID = (state_q == ISSUE);
    bus.CMD_REF   = cmd_ref_q;
    bus.CMD_RW    = cmd_rw_q;
    bus.CMD_ADR   = cmd_adr_q;
    bus.GNT       = gnt_q;
    bus.ACK       = ((state_q == WAIT_DONE) && bus.CMD_DONE) ? gnt_q : '0;
    BUSY          = (state_q != IDLE);
    REF_OVERDUE   = (pending_q == PEND_W'(MAX_PENDING));
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios with literal expectations
// plus a long randomized run, all compared every cycle against a transaction-level model.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 24;
  localparam int RI = 16;
  localparam int MP = 8;
  localparam int UL = 4;

  logic CLK = 1'b0;
  logic NRST = 1'b0;
  logic INIT_DONE = 1'b0;
  logic BUSY;
  logic REF_OVERDUE;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  sdram_port_arbiter_if #(.NPORTS(NP), .ADDR_W(AW)) bus ();

  sdram_port_arbiter #(
    .NPORTS(NP), .ADDR_W(AW), .REFR_INTERVAL(RI), .MAX_PENDING(MP), .URGENT_LEVEL(UL)
  ) dut (
    .CLK(CLK), .NRST(NRST), .INIT_DONE(INIT_DONE),
    .bus(bus.master), .BUSY(BUSY), .REF_OVERDUE(REF_OVERDUE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 = free, 1 = command offered, 2 = command in flight.
  int          m_phase = 0;
  int          m_pend = 0;
  int          m_timer = 0;
  int          m_ptr = 0;
  int          m_port = -1;
  int          m_done_port = -1;
  bit          m_ref = 1'b0;
  bit          m_rw = 1'b0;
  logic [AW-1:0] m_adr = '0;
  bit          chk_en = 1'b0;

  always @(posedge CLK) begin : model
    int p, q, first;
    bit tk, rd;
    m_done_port = -1;
    if (!NRST) begin
      m_phase = 0; m_pend = 0; m_timer = 0; m_ptr = 0; m_port = -1;
      m_ref = 1'b0; m_rw = 1'b0; m_adr = '0;
      chk_en = 1'b1;
    end else begin
      tk = INIT_DONE && (m_timer == RI - 1);
      rd = (m_phase == 2) && bus.CMD_DONE && m_ref;
      case (m_phase)
        0: if (INIT_DONE && (m_pend > 0 || bus.REQ != 0)) begin
          if (m_pend >= UL || bus.REQ == 0) begin
            m_ref = 1'b1; m_port = -1;
          end else begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            first = 0;
`else
            first = m_ptr;
`endif
            p = -1;
            for (int k = 0; k < NP; k++) begin
              q = (first + k) % NP;
              if (p < 0 && bus.REQ[q]) p = q;
            end
            m_ref = 1'b0; m_port = p;
            m_rw = bus.RW[p];
            m_adr = bus.ADR[p*AW +: AW];
            m_ptr = (p + 1) % NP;
          end
          m_phase = 1;
        end
        1: if (bus.CMD_READY) m_phase = 2;
        2: if (bus.CMD_DONE) begin m_done_port = m_port; m_phase = 0; end
        default: m_phase = 0;
      endcase
      m_pend = m_pend + (tk ? 1 : 0) - (rd ? 1 : 0);
      if (m_pend > MP) m_pend = MP;
      m_timer = (INIT_DONE && !tk) ? m_timer + 1 : 0;
    end
  end

  always @(negedge CLK) begin : compare
    logic [NP-1:0] eg, ea;
    if (chk_en) begin
      eg = (m_phase != 0 && m_port >= 0) ? (NP'(1) << m_port) : '0;
      ea = (m_phase == 2 && bus.CMD_DONE) ? eg : '0;
      chk("GNT", 32'(bus.GNT), 32'(eg));
      chk("ACK", 32'(bus.ACK), 32'(ea));
      chk("CMD_VALID", 32'(bus.CMD_VALID), 32'(m_phase == 1));
      chk("BUSY", 32'(BUSY), 32'(m_phase != 0));
      chk("REF_OVERDUE", 32'(REF_OVERDUE), 32'(m_pend == MP));
      if (m_phase != 0) chk("CMD_REF", 32'(bus.CMD_REF), 32'(m_ref));
      if (m_phase == 1 && !m_ref) begin
        chk("CMD_RW", 32'(bus.CMD_RW), 32'(m_rw));
        chk("CMD_ADR", 32'(bus.CMD_ADR), 32'(m_adr));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  task automatic applyStimulus(input bit rdy);
    cyc();
    bus.CMD_READY = rdy;
    bus.CMD_DONE  = (m_phase == 2);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    NRST = 1'b0;
    bus.REQ = '0; bus.RW = '0; bus.ADR = '0;
    bus.CMD_READY = 1'b0; bus.CMD_DONE = 1'b0;
    cyc(); cyc();
    NRST = 1'b1;
    INIT_DONE = 1'b1;
    cyc_n = 0;
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    int r = -1;
    for (int i = 0; i < NP; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin : main
    int got[6];
    int ng, first_ref, next_gnt, nref, last_ref;
    bit seen_ref;

    bus.REQ = '0; bus.RW = '0; bus.ADR = '0;
    bus.CMD_READY = 1'b0; bus.CMD_DONE = 1'b0;

    // Reset values and a single write from port 0.
    do_reset();
    bus.REQ = 3'b001; bus.RW = 3'b001; bus.ADR[0 +: AW] = 24'h123456;
    @(negedge CLK);
    chk("lit_reset_busy", 32'(BUSY), 0);
    chk("lit_reset_gnt", 32'(bus.GNT), 0);
    chk("lit_reset_valid", 32'(bus.CMD_VALID), 0);
    chk("lit_reset_adr", 32'(bus.CMD_ADR), 0);
    chk("lit_reset_overdue", 32'(REF_OVERDUE), 0);
    cyc(); @(negedge CLK);
    chk("lit_t1_valid", 32'(bus.CMD_VALID), 1);
    chk("lit_t1_adr", 32'(bus.CMD_ADR), 32'h123456);
    chk("lit_t1_rw", 32'(bus.CMD_RW), 1);
    chk("lit_t1_gnt", 32'(bus.GNT), 32'b001);
    chk("lit_t1_ref", 32'(bus.CMD_REF), 0);
    cyc(); bus.CMD_READY = 1'b1; @(negedge CLK);
    cyc(); bus.CMD_READY = 1'b0; bus.CMD_DONE = 1'b1; @(negedge CLK);
    chk("lit_t1_ack", 32'(bus.ACK), 32'b001);
    chk("lit_t1_wait_valid", 32'(bus.CMD_VALID), 0);
    cyc(); bus.CMD_DONE = 1'b0; bus.REQ = '0; @(negedge CLK);
    chk("lit_t1_ack_gone", 32'(bus.ACK), 0);
    chk("lit_t1_busy_end", 32'(BUSY), 0);
    chk("lit_t1_gnt_end", 32'(bus.GNT), 0);

    // All ports requesting continuously: grant order.
    do_reset();
    bus.REQ = 3'b111; bus.RW = 3'b010;
    for (int i = 0; i < NP; i++) bus.ADR[i*AW +: AW] = AW'(24'h100000 * (i + 1));
    ng = 0;
    for (int n = 0; n < 40 && ng < 6; n++) begin
      applyStimulus(1'b1);
      if (bus.CMD_VALID) begin got[ng] = onehot_idx(bus.GNT); ng++; end
    end
    chk("lit_rr_count", 32'(ng), 6);
    for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      chk("lit_order", 32'(got[k]), 0);
`else
      chk("lit_order", 32'(got[k]), 32'(k % NP));
`endif
    end
    bus.REQ = '0;

    // Idle refresh pulse train.
    do_reset();
    nref = 0; first_ref = -1; last_ref = 0;
    for (int n = 0; n < 70; n++) begin
      applyStimulus(1'b1);
      if (bus.CMD_VALID) begin
        chk("lit_idle_ref", 32'(bus.CMD_REF), 1);
        if (nref == 0) first_ref = cyc_n;
        else chk("lit_ref_spacing", 32'(cyc_n - last_ref), RI);
        last_ref = cyc_n; nref++;
      end
    end
    chk("lit_ref_first", 32'(first_ref), 17);
    chk("lit_ref_count", 32'(nref), 4);
    chk("lit_ref_busy_end", 32'(BUSY), 0);
    chk("lit_model_pend_zero", 32'(m_pend), 0);

    // Port 0 hogging; refresh pre-empts once four are pending.
    do_reset();
    bus.REQ = 3'b001; bus.ADR[0 +: AW] = 24'h00BEEF;
    first_ref = -1; next_gnt = -2; seen_ref = 1'b0;
    for (int n = 0; n < 90 && next_gnt == -2; n++) begin
      applyStimulus(1'b1);
      if (bus.CMD_VALID) begin
        if (bus.CMD_REF && !seen_ref) begin seen_ref = 1'b1; first_ref = cyc_n; end
        else if (seen_ref) next_gnt = onehot_idx(bus.GNT);
      end
    end
    chk("lit_urgent_when", 32'(first_ref), 67);
    chk("lit_urgent_next_port", 32'(next_gnt), 0);
    bus.REQ = '0;

    // Controller stalls: refresh debt saturates, command held stable.
    do_reset();
    bus.REQ = 3'b001; bus.RW = 3'b000; bus.ADR[0 +: AW] = 24'hABCDEF;
    for (int n = 0; n < 160; n++) begin
      applyStimulus(1'b0);
      chk("lit_stall_valid", 32'(bus.CMD_VALID), 1);
      chk("lit_stall_adr", 32'(bus.CMD_ADR), 32'hABCDEF);
      if (cyc_n == 127) chk("lit_overdue_before", 32'(REF_OVERDUE), 0);
      if (cyc_n == 128) chk("lit_overdue_at", 32'(REF_OVERDUE), 1);
    end
    chk("lit_overdue_held", 32'(REF_OVERDUE), 1);
    bus.REQ = '0;
    for (int n = 0; n < 60; n++) applyStimulus(1'b1);
    chk("lit_overdue_drained", 32'(REF_OVERDUE), 0);

    // Reset while a command is in flight.
    do_reset();
    bus.REQ = 3'b010; bus.ADR[AW +: AW] = 24'h0F0F0F;
    for (int n = 0; n < 40; n++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    cyc(); bus.CMD_READY = 1'b0; bus.CMD_DONE = 1'b0; @(negedge CLK);
    chk("lit_rst_pre_busy", 32'(BUSY), 1);
    chk("lit_rst_pre_gnt", 32'(bus.GNT), 32'b010);
    cyc(); NRST = 1'b0;
    cyc(); NRST = 1'b1; bus.REQ = '0; bus.CMD_DONE = 1'b1; cyc_n = 0;
    @(negedge CLK);
    chk("lit_rst_gnt", 32'(bus.GNT), 0);
    chk("lit_rst_valid", 32'(bus.CMD_VALID), 0);
    chk("lit_rst_busy", 32'(BUSY), 0);
    chk("lit_rst_overdue", 32'(REF_OVERDUE), 0);
    chk("lit_rst_stale_ack", 32'(bus.ACK), 0);
    cyc(); bus.CMD_DONE = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge CLK);
      chk("lit_rst_pend_cleared", 32'(BUSY), 0);
      cyc();
    end

    // Randomized traffic with stray handshakes, INIT_DONE drops and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      NRST = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 63) == 0) INIT_DONE = ~INIT_DONE;
      for (int i = 0; i < NP; i++) begin
        if (m_done_port == i) bus.REQ[i] = 1'b0;
        else if (!bus.REQ[i] && $urandom_range(0, 5) == 0) begin
          bus.REQ[i] = 1'b1;
          bus.RW[i] = 1'($urandom);
          bus.ADR[i*AW +: AW] = AW'($urandom);
        end
      end
      bus.CMD_READY = ($urandom_range(0, 2) == 0);
      bus.CMD_DONE  = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end
    cyc();
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
